// File: rtl/enc_div_multi.sv
// Multi-channel quadrature step divider. It emits one registered pulse for every
// div_eff same-direction steps and keeps a saturating signed position count per channel.
module enc_div_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 4,
  parameter int POS_W   = 16,
  parameter int DEF_DIV = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CNT_W-1:0]        div_ratio,
  input  logic                    div_load,
  input  logic                    mode,
  input  logic [NUM_CH-1:0]       cw_in,
  input  logic [NUM_CH-1:0]       ccw_in,
  input  logic [NUM_CH-1:0]       clr_pos,
  output logic [NUM_CH-1:0]       cw_out,
  output logic [NUM_CH-1:0]       ccw_out,
  output logic [NUM_CH*POS_W-1:0] pos,
  output logic [NUM_CH-1:0]       err
);

  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic signed [POS_W-1:0] POS_ONE = 1;
  localparam logic signed [CNT_W:0]   NET_ONE = 1;

  logic [CNT_W-1:0]        div_reg;
  logic [CNT_W-1:0]        thr;
  logic signed [CNT_W:0]   thr_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      div_reg <= CNT_W'(DEF_DIV);
    else if (div_load) div_reg <= div_ratio;
  end

  // A ratio of 0 behaves as 1, so the firing threshold is div_eff-1.
  assign thr   = (div_reg == '0) ? '0 : div_reg - 1'b1;
  assign thr_s = $signed({1'b0, thr});

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0]        cw_acc, ccw_acc, cw_acc_nx, ccw_acc_nx;
    logic signed [CNT_W:0]   net_acc, net_acc_nx;
    logic signed [POS_W-1:0] pos_q;
    logic                    cw_q, ccw_q, err_q;
    logic                    cw_fire, ccw_fire, both;

    always_comb begin
      cw_fire    = 1'b0;
      ccw_fire   = 1'b0;
      both       = 1'b0;
      cw_acc_nx  = cw_acc;
      ccw_acc_nx = ccw_acc;
      net_acc_nx = net_acc;
      if (div_load) begin
        cw_acc_nx  = '0;
        ccw_acc_nx = '0;
        net_acc_nx = '0;
      end else if (cw_in[g] && ccw_in[g]) begin
        both = 1'b1;
      end else if (cw_in[g]) begin
        if (!mode) begin
          ccw_acc_nx = '0;
          if (cw_acc >= thr) begin
            cw_fire   = 1'b1;
            cw_acc_nx = '0;
          end else begin
            cw_acc_nx = cw_acc + 1'b1;
          end
        end else if (net_acc >= thr_s) begin
          cw_fire    = 1'b1;
          net_acc_nx = '0;
        end else begin
          net_acc_nx = net_acc + NET_ONE;
        end
      end else if (ccw_in[g]) begin
        if (!mode) begin
          cw_acc_nx = '0;
          if (ccw_acc >= thr) begin
            ccw_fire   = 1'b1;
            ccw_acc_nx = '0;
          end else begin
            ccw_acc_nx = ccw_acc + 1'b1;
          end
        end else if (net_acc <= -thr_s) begin
          ccw_fire   = 1'b1;
          net_acc_nx = '0;
        end else begin
          net_acc_nx = net_acc - NET_ONE;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cw_acc  <= '0;
        ccw_acc <= '0;
        net_acc <= '0;
        cw_q    <= 1'b0;
        ccw_q   <= 1'b0;
        err_q   <= 1'b0;
        pos_q   <= '0;
      end else begin
        cw_acc  <= cw_acc_nx;
        ccw_acc <= ccw_acc_nx;
        net_acc <= net_acc_nx;
        cw_q    <= cw_fire;
        ccw_q   <= ccw_fire;
        // Clearing wins over this cycle's count and error, but not over the pulse.
        if (clr_pos[g]) begin
          pos_q <= '0;
          err_q <= 1'b0;
        end else begin
          if (cw_fire && pos_q != POS_MAX)       pos_q <= pos_q + POS_ONE;
          else if (ccw_fire && pos_q != POS_MIN) pos_q <= pos_q - POS_ONE;
          if (both) err_q <= 1'b1;
        end
      end
    end

    assign cw_out[g]                = cw_q;
    assign ccw_out[g]               = ccw_q;
    assign err[g]                   = err_q;
    assign pos[g*POS_W +: POS_W]    = pos_q;
  end

endmodule

// File: tb/tb_enc_div_multi.sv
// Self-checking bench for enc_div_multi with a narrow position counter so saturation is reachable.
// The reference model counts runs and net displacement directly.
module tb_enc_div_multi;
  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 4;
  localparam int POS_W   = 4;
  localparam int DEF_DIV = 3;
  localparam int VW      = 3*NUM_CH + NUM_CH*POS_W;
  localparam int PMAX    = 2**(POS_W-1) - 1;
  localparam int PMIN    = -(2**(POS_W-1));

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [CNT_W-1:0]        div_ratio;
  logic                    div_load, mode;
  logic [NUM_CH-1:0]       cw_in, ccw_in, clr_pos;
  logic [NUM_CH-1:0]       cw_out, ccw_out, err;
  logic [NUM_CH*POS_W-1:0] pos;

  int errors = 0;
  int checks = 0;

  int m_pos [NUM_CH];
  int m_run [NUM_CH];
  int m_dir [NUM_CH];
  int m_net [NUM_CH];
  bit m_err [NUM_CH];
  bit m_cw  [NUM_CH];
  bit m_ccw [NUM_CH];
  int m_div;

  always #5 clk = ~clk;

  enc_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .POS_W(POS_W), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .div_ratio(div_ratio), .div_load(div_load), .mode(mode),
    .cw_in(cw_in), .ccw_in(ccw_in), .clr_pos(clr_pos),
    .cw_out(cw_out), .ccw_out(ccw_out), .pos(pos), .err(err)
  );

  task automatic model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_pos[ch] = 0; m_run[ch] = 0; m_dir[ch] = 0; m_net[ch] = 0;
      m_err[ch] = 0; m_cw[ch] = 0; m_ccw[ch] = 0;
    end
    m_div = DEF_DIV;
  endtask

  task automatic model_step(input logic [NUM_CH-1:0] c, input logic [NUM_CH-1:0] cc,
                            input logic [NUM_CH-1:0] cl, input bit ld,
                            input logic [CNT_W-1:0] rat, input bit md);
    int deff, d;
    bit both;
    deff = (m_div == 0) ? 1 : m_div;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_cw[ch] = 0; m_ccw[ch] = 0; both = 0; d = 0;
      if (ld) begin
        m_run[ch] = 0; m_net[ch] = 0;
      end else if (c[ch] && cc[ch]) begin
        both = 1;
      end else if (c[ch] || cc[ch]) begin
        d = c[ch] ? 1 : -1;
        if (!md) begin
          if (m_dir[ch] != d) begin m_dir[ch] = d; m_run[ch] = 0; end
          m_run[ch]++;
          if (m_run[ch] == deff) begin
            m_run[ch] = 0;
            if (d > 0) m_cw[ch] = 1; else m_ccw[ch] = 1;
          end
        end else begin
          m_net[ch] += d;
          if (m_net[ch] == deff)  begin m_cw[ch]  = 1; m_net[ch] = 0; end
          if (m_net[ch] == -deff) begin m_ccw[ch] = 1; m_net[ch] = 0; end
        end
      end
      if (cl[ch]) begin
        m_pos[ch] = 0; m_err[ch] = 0;
      end else begin
        if (m_cw[ch]  && m_pos[ch] < PMAX) m_pos[ch]++;
        if (m_ccw[ch] && m_pos[ch] > PMIN) m_pos[ch]--;
        if (both) m_err[ch] = 1;
      end
    end
    if (ld) m_div = rat;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [NUM_CH-1:0]       a, b, e;
    logic [NUM_CH*POS_W-1:0] p;
    int v;
    a = '0; b = '0; e = '0; p = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      a[ch] = m_cw[ch]; b[ch] = m_ccw[ch]; e[ch] = m_err[ch];
      v = m_pos[ch];
      p[ch*POS_W +: POS_W] = v[POS_W-1:0];
    end
    return {a, b, e, p};
  endfunction

  // Drives one cycle of stimulus from just after an edge; returns 1 time unit after the next edge.
  task automatic apply(input logic [NUM_CH-1:0] c, input logic [NUM_CH-1:0] cc,
                       input logic [NUM_CH-1:0] cl, input bit ld, input logic [CNT_W-1:0] rat);
    cw_in = c; ccw_in = cc; clr_pos = cl; div_load = ld; div_ratio = rat;
    @(posedge clk);
    model_step(c, cc, cl, ld, rat, mode);
    #1;
    cw_in = '0; ccw_in = '0; clr_pos = '0; div_load = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mode = 1'b0; div_load = 1'b0; div_ratio = '0;
    cw_in = '0; ccw_in = '0; clr_pos = '0;
    model_reset();
    #2;
    checks++; if (cw_out !== '0)  begin errors++; $display("FAIL reset_cw_out got %h expected 0", cw_out); end
    checks++; if (ccw_out !== '0) begin errors++; $display("FAIL reset_ccw_out got %h expected 0", ccw_out); end
    checks++; if (pos !== '0)     begin errors++; $display("FAIL reset_pos got %h expected 0", pos); end
    checks++; if (err !== '0)     begin errors++; $display("FAIL reset_err got %h expected 0", err); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_div3_ch0();
    logic [NUM_CH-1:0] seq [6];
    seq = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      apply(seq[i], '0, '0, 1'b0, '0);
      checks++;
      if ({cw_out, ccw_out, err, pos} !== exp_vec()) begin
        errors++; $display("FAIL div3_ch0 step %0d got %h expected %h", i, {cw_out, ccw_out, err, pos}, exp_vec());
      end
    end
  endtask

  task automatic test_reversal_reset_mode();
    logic [1:0] seq [6];
    seq = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10};
    mode = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) apply({2'b00, seq[i][1], 1'b0}, {2'b00, seq[i][0], 1'b0}, '0, 1'b0, '0);
      else       apply('0, '0, '0, 1'b0, '0);
      checks++;
      if ({cw_out, ccw_out, err, pos} !== exp_vec()) begin
        errors++; $display("FAIL reversal_reset step %0d got %h expected %h", i, {cw_out, ccw_out, err, pos}, exp_vec());
      end
    end
  endtask

  task automatic test_net_mode();
    logic [1:0] seq [10];
    seq = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
    mode = 1'b1;
    apply('0, '0, '0, 1'b1, 4'd4);
    for (int i = 0; i < 10; i++) begin
      apply({1'b0, seq[i][1], 2'b00}, {1'b0, seq[i][0], 2'b00}, '0, 1'b0, '0);
      checks++;
      if ({cw_out, ccw_out, err, pos} !== exp_vec()) begin
        errors++; $display("FAIL net_mode step %0d got %h expected %h", i, {cw_out, ccw_out, err, pos}, exp_vec());
      end
    end
    checks++;
    if (pos[2*POS_W +: POS_W] !== '0) begin
      errors++; $display("FAIL net_mode_pos2 got %0d expected 0", pos[2*POS_W +: POS_W]);
    end
  endtask

  task automatic test_div_zero();
    mode = 1'b0;
    apply('0, '0, '0, 1'b1, 4'd2);
    apply(4'b0001, '0, '0, 1'b0, '0);
    apply(4'b0001, '0, '0, 1'b1, 4'd0);
    checks++;
    if ({cw_out, ccw_out, err, pos} !== exp_vec()) begin
      errors++; $display("FAIL div_zero_load_drop got %h expected %h", {cw_out, ccw_out, err, pos}, exp_vec());
    end
    for (int i = 0; i < 5; i++) begin
      apply(4'b0001, '0, '0, 1'b0, '0);
      checks++;
      if ({cw_out, ccw_out, err, pos} !== exp_vec()) begin
        errors++; $display("FAIL div_zero step %0d got %h expected %h", i, {cw_out, ccw_out, err, pos}, exp_vec());
      end
    end
  endtask

  task automatic test_err_clear();
    mode = 1'b0;
    apply('0, '0, '0, 1'b1, 4'd3);
    apply(4'b1000, '0, '0, 1'b0, '0);
    apply(4'b1000, 4'b1000, '0, 1'b0, '0);
    checks++;
    if ({cw_out, ccw_out, err, pos} !== exp_vec()) begin
      errors++; $display("FAIL err_set got %h expected %h", {cw_out, ccw_out, err, pos}, exp_vec());
    end
    apply(4'b1000, '0, '0, 1'b0, '0);
    apply(4'b1000, '0, '0, 1'b0, '0);
    checks++;
    if ({cw_out, ccw_out, err, pos} !== exp_vec()) begin
      errors++; $display("FAIL err_acc_held got %h expected %h", {cw_out, ccw_out, err, pos}, exp_vec());
    end
    apply(4'b1000, '0, '0, 1'b0, '0);
    apply(4'b1000, '0, '0, 1'b0, '0);
    apply(4'b1000, 4'b1000, 4'b1000, 1'b0, '0);
    checks++;
    if ({cw_out, ccw_out, err, pos} !== exp_vec()) begin
      errors++; $display("FAIL clr_with_err got %h expected %h", {cw_out, ccw_out, err, pos}, exp_vec());
    end
    checks++;
    if (err[3] !== 1'b0) begin errors++; $display("FAIL clr_err3 got %b expected 0", err[3]); end
  endtask

  task automatic test_saturation();
    mode = 1'b0;
    apply('0, '0, '0, 1'b1, 4'd0);
    for (int i = 0; i < 9; i++) apply(4'b0001, '0, '0, 1'b0, '0);
    checks++;
    if ($signed(pos[POS_W-1:0]) !== 4'sd7) begin
      errors++; $display("FAIL sat_pos_max got %0d expected 7", $signed(pos[POS_W-1:0]));
    end
    for (int i = 0; i < 18; i++) begin
      apply('0, 4'b0001, '0, 1'b0, '0);
      checks++;
      if ({cw_out, ccw_out, err, pos} !== exp_vec()) begin
        errors++; $display("FAIL sat_down step %0d got %h expected %h", i, {cw_out, ccw_out, err, pos}, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    mode = 1'b0;
    apply(4'b0101, '0, '0, 1'b0, '0);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({cw_out, ccw_out, err, pos} !== '0) begin
      errors++; $display("FAIL async_reset got %h expected 0", {cw_out, ccw_out, err, pos});
    end
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply(4'b0010, '0, '0, 1'b0, '0);
      checks++;
      if ({cw_out, ccw_out, err, pos} !== exp_vec()) begin
        errors++; $display("FAIL def_div step %0d got %h expected %h", i, {cw_out, ccw_out, err, pos}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] c, cc, cl;
    bit ld;
    logic [CNT_W-1:0] rat;
    for (int i = 0; i < 400; i++) begin
      c  = NUM_CH'($urandom);
      cc = NUM_CH'($urandom);
      if ($urandom_range(0, 7) != 0) cc = cc & ~c;
      cl = ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom) : '0;
      ld = ($urandom_range(0, 19) == 0);
      rat = CNT_W'($urandom_range(0, 6));
      if (ld && $urandom_range(0, 1) == 1) mode = ~mode;
      apply(c, cc, cl, ld, rat);
      checks++;
      if ({cw_out, ccw_out, err, pos} !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d got %h expected %h", i, {cw_out, ccw_out, err, pos}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_div3_ch0();
    test_reversal_reset_mode();
    test_net_mode();
    test_div_zero();
    test_err_clear();
    test_saturation();
    test_async_reset();
    // Mode only changes together with a load, so leave mode 0 with a cleared state first.
    mode = 1'b0;
    apply('0, '0, '0, 1'b1, 4'd3);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/enc_div_multi.md
Name: enc_div_multi

Overview:
- Multi-channel, parametrised quadrature step divider; successor to the fixed divide-by-3 single-channel step divider.
- Takes per-channel single-cycle cw/ccw step pulses from the quadrature decoders and emits one output pulse per programmable number of same-direction steps.
- Keeps a saturating signed position count per channel and flags illegal simultaneous cw/ccw input.
- Sits between the decoder bank and the arm joint controllers; one instance serves all joints.

Parameters:
NUM_CH, 4, number of independent encoder channels
CNT_W, 4, width of divide ratio and step accumulator magnitude
POS_W, 16, width of signed per-channel position counter
DEF_DIV, 3, divide ratio loaded at reset (must be < 2**CNT_W)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
div_ratio  in  CNT_W  new divide ratio, sampled when div_load=1
div_load  in  1  load div_ratio and clear all accumulators
mode  in  1  0 = RESET mode (reversal clears), 1 = NET mode (reversal decrements)
cw_in  in  NUM_CH  per-channel cw step pulse
ccw_in  in  NUM_CH  per-channel ccw step pulse
clr_pos  in  NUM_CH  per-channel synchronous position/error clear
cw_out  out  NUM_CH  1-cycle pulse per div same-direction cw steps
ccw_out  out  NUM_CH  1-cycle pulse per div ccw steps
pos  out  NUM_CH*POS_W  packed signed positions, channel 0 in LSBs
err  out  NUM_CH  sticky: cw_in and ccw_in high in same cycle

Behaviour:
- Reset is asynchronous, active-low. On reset: cw_out=0, ccw_out=0, pos=0, err=0, all accumulators=0, div_reg=DEF_DIV.
- Effective divide ratio: div_eff = (div_reg==0) ? 1 : div_reg.
- Outputs are registered. A pulse asserts on the clock edge that samples the completing input step, so it is visible the cycle after that step. Pulses default to 0 every cycle and are never wider than 1 cycle.
- div_load=1: div_reg<=div_ratio; every channel accumulator <= 0; all step inputs in that cycle are dropped (no pulse, no pos change). pos and err are unaffected. mode may change at any time; an accumulator value left from the other mode is clamped by the rules below only on the next event. Integration clears accumulators via div_load when changing mode.
- RESET mode (mode=0), per channel, using unsigned cw_acc and ccw_acc:
  - cw_in only: ccw_acc<=0. If cw_acc >= div_eff-1: cw_out<=1, cw_acc<=0. Else cw_acc<=cw_acc+1.
  - ccw_in only: symmetric.
  - Neither input: accumulators hold.
- NET mode (mode=1), per channel, using signed acc of CNT_W+1 bits, range -(div_eff-1)..+(div_eff-1):
  - cw_in only: if acc >= div_eff-1: cw_out<=1, acc<=0. Else acc<=acc+1.
  - ccw_in only: if acc <= -(div_eff-1): ccw_out<=1, acc<=0. Else acc<=acc-1.
- Simultaneous cw_in and ccw_in on a channel (either mode): accumulators unchanged, no pulse, err<=1.
- pos: +1 on the same edge cw_out is set, -1 on the same edge ccw_out is set. Saturates at +(2**(POS_W-1)-1) and -(2**(POS_W-1)); no wrap.
- clr_pos[i]=1: pos[i]<=0 and err[i]<=0. Takes priority over that cycle's increment and err set. The output pulse and accumulator update still occur.
- Channels are fully independent; any combination may pulse in the same cycle.

Test Plan:
- Reset, then 3 cw_in pulses on ch0, mode=0, div=3 -> cw_out[0] high exactly 1 cycle after the 3rd pulse; pos[0]=1; other channels silent.
- mode=0, div=3, ch1 sequence cw,cw,ccw,cw,cw,cw -> no pulse until the final cw; single cw_out[1]; pos[1]=1.
- mode=1, div=4, ch2 sequence cw,cw,ccw,cw,cw,cw -> cw_out[2] after the 6th input (net +4); pos[2]=1. A following 4x ccw -> one ccw_out[2]; pos[2]=0.
- div_load with div_ratio=0 mid-accumulation -> accumulators cleared; subsequent single cw_in gives cw_out every cycle (div_eff=1).
- cw_in[3] and ccw_in[3] high together -> err[3]=1, no pulse, accumulator unchanged; then clr_pos[3] -> err[3]=0, pos[3]=0.
- POS_W=4: 9 cw_out events on ch0 -> pos[0] saturates at +7. Assert reset_n low mid-sequence -> all outputs 0 immediately, div_reg=DEF_DIV.
